// File: rtl/booth_mul_32_pkg.sv
// Shared constants for the radix-2 Booth multiplier: state encodings,
// default operand width and Booth pair decode values.
package booth_mul_32_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // {Q[0], q_-1} decode
    localparam logic [1:0] PAIR_NOP0 = 2'b00;
    localparam logic [1:0] PAIR_ADD  = 2'b01;
    localparam logic [1:0] PAIR_SUB  = 2'b10;
    localparam logic [1:0] PAIR_NOP1 = 2'b11;

endpackage

// File: rtl/booth_addsub_33.sv
// 33-bit ripple-carry add/subtract for the Booth accumulator.
// Subtract inverts b and injects carry-in = 1.
module booth_addsub_33 #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff;
    logic [W-1:0] carry;

    // Chain of full adders, carry rippling from bit 0 upward
    always_comb begin
        b_eff    = b ^ {W{sub}};
        carry    = '0;
        carry[0] = sub;
        sum      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry[i];
            if (i + 1 < W) begin
                carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
            end
        end
    end

endmodule

// File: rtl/booth_mul_32.sv
// Sequential radix-2 Booth multiplier, signed 32x32 -> 64-bit {hi,lo}.
// One Booth step per RUN cycle; done pulses for one cycle when hi/lo are valid.
// Optional macro BOOTH_EARLY_EXIT_EN collapses the trailing run of
// no-add steps into one arithmetic shift and finishes early.
module booth_mul_32
    import booth_mul_32_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [1:0]     state;
    logic [WIDTH:0] a_reg;
    logic [WIDTH:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic           q_m1;
    logic [CW-1:0]  count;

    logic [1:0]     pair;
    logic           do_sub;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] step_a;

    logic [WIDTH:0]   run_a;
    logic [WIDTH-1:0] run_q;
    logic             run_qm1;
    logic             run_last;

    assign pair   = {q_reg[0], q_m1};
    assign do_sub = (pair == PAIR_SUB);

    booth_addsub_33 #(.W(WIDTH + 1)) u_addsub (
        .a   (a_reg),
        .b   (m_reg),
        .sub (do_sub),
        .sum (sum)
    );

`ifdef BOOTH_EARLY_EXIT_EN
    logic [WIDTH-1:0]          live_mask;
    logic                      early;
    logic [CW:0]               shift_amt;
    logic signed [2*WIDTH:0]   aq;
    logic signed [2*WIDTH:0]   aq_shifted;

    // Remaining multiplier bits sit in q_reg[WIDTH-1-count:0]; if they all
    // match q_-1 every remaining pair is 00/11, i.e. a pure shift.
    always_comb begin
        live_mask  = {WIDTH{1'b1}} >> count;
        early      = (((q_reg ^ {WIDTH{q_m1}}) & live_mask) == '0);
        shift_amt  = (CW + 1)'(WIDTH) - {1'b0, count};
        aq         = {a_reg, q_reg};
        aq_shifted = aq >>> shift_amt;
    end
`endif

    // Next accumulator/multiplier values for one RUN cycle
    always_comb begin
        if (pair == PAIR_ADD || pair == PAIR_SUB) begin
            step_a = sum;
        end else begin
            step_a = a_reg;
        end
        run_a    = {step_a[WIDTH], step_a[WIDTH:1]};
        run_q    = {step_a[0], q_reg[WIDTH-1:1]};
        run_qm1  = q_reg[0];
        run_last = (count == CW'(WIDTH - 1));
`ifdef BOOTH_EARLY_EXIT_EN
        if (early) begin
            run_a    = aq_shifted[2*WIDTH:WIDTH];
            run_q    = aq_shifted[WIDTH-1:0];
            run_last = 1'b1;
        end
`endif
    end

    // Control FSM, shift register, step counter and result registers
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
            a_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_reg <= {multiplicand[WIDTH-1], multiplicand};
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_m1  <= 1'b0;
                        count <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_reg <= run_a;
                    q_reg <= run_q;
                    q_m1  <= run_qm1;
                    count <= count + 1'b1;
                    if (run_last) begin
                        state <= ST_DONE;
                        hi    <= run_a[WIDTH-1:0];
                        lo    <= run_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_booth_mul_32.sv
// Directed self-checking bench for booth_mul_32.
// Expected latencies follow BOOTH_EARLY_EXIT_EN when it is defined.
module tb_booth_mul_32;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    localparam int LAT_FULL = 33;
`ifdef BOOTH_EARLY_EXIT_EN
    localparam int LAT_SMALL = 6;
`else
    localparam int LAT_SMALL = 33;
`endif

    booth_mul_32 dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b1;
        multiplicand = 32'd3;
        multiplier = 32'd5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_run: busy got %b want 0", busy); end
    endtask

    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int cyc;
        bit seen;
        @(negedge clock);
        multiplicand = m;
        multiplier = q;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_c1: got %b want 1", name, busy); end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
        end else begin
            checks++; if (cyc != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_lat); end
            checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi: got %h want %h", name, hi, exp_hi); end
            checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo: got %h want %h", name, lo, exp_lo); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done: got %b want 0", name, busy); end
            @(negedge clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done); end
            checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi_hold: got %h want %h", name, hi, exp_hi); end
        end
    endtask

    task automatic test_products();
        run_op(32'd3, 32'd5, LAT_SMALL, 32'h0000_0000, 32'h0000_000F, "mul_3x5");
        run_op(32'hFFFF_FFF9, 32'd6, LAT_SMALL, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "mul_m7x6");
        run_op(32'h8000_0000, 32'h8000_0000, LAT_FULL, 32'h4000_0000, 32'h0000_0000, "mul_min_min");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, LAT_FULL, 32'h3FFF_FFFF, 32'h0000_0001, "mul_max_max");
    endtask

    // 3 x 0x40000001 = 0xC0000003; multiplier has no trailing uniform run, so 33 cycles in both builds
    task automatic test_ignored_start();
        int cyc;
        bit seen;
        @(negedge clock);
        multiplicand = 32'd3;
        multiplier = 32'h4000_0001;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
            else if (cyc == 10) begin
                multiplicand = 32'd7;
                multiplier = 32'd7;
                start = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_start_timeout: no done within %0d cycles", cyc);
        end else begin
            checks++; if (cyc != LAT_FULL) begin errors++; $display("FAIL ignore_start_latency: got %0d want %0d", cyc, LAT_FULL); end
            checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_start_hi: got %h want 00000000", hi); end
            checks++; if (lo !== 32'hC000_0003) begin errors++; $display("FAIL ignore_start_lo: got %h want c0000003", lo); end
        end
    endtask

    task automatic test_clear_mid_run();
        int saw_done;
        @(negedge clock);
        multiplicand = 32'd3;
        multiplier = 32'h4000_0001;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (12) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before: got %b want 1", busy); end
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL clear_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL clear_lo: got %h want 00000000", lo); end
        saw_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) saw_done++;
        end
        checks++; if (saw_done != 0) begin errors++; $display("FAIL clear_no_done: got %0d done cycles want 0", saw_done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        @(negedge clock);
        multiplicand = 32'd3;
        multiplier = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_first_timeout: no done within %0d cycles", cyc);
            return;
        end
        checks++; if (lo !== 32'h0000_000F) begin errors++; $display("FAIL b2b_first_lo: got %h want 0000000f", lo); end
        multiplicand = 32'hFFFF_FFF9;
        multiplier = 32'd6;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        cyc = 1;
        seen = (done === 1'b1);
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_second_timeout: no done within %0d cycles", cyc);
        end else begin
            checks++; if (cyc != LAT_SMALL) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT_SMALL); end
            checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi: got %h want ffffffff", hi); end
            checks++; if (lo !== 32'hFFFF_FFD6) begin errors++; $display("FAIL b2b_lo: got %h want ffffffd6", lo); end
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_ignored_start();
        test_clear_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
